// File: rtl/bp_be_int_wb_arbiter_pkg.sv
// Shared types for the integer write-back arbiter slice.
package bp_be_pkg;

    // Write-port source tag carried on wb_src_o
    typedef enum logic {
        e_wb_src_int  = 1'b0,
        e_wb_src_long = 1'b1
    } bp_be_wb_src_e;

    // Arbiter mode: normal arbitration, or dispatch stalled to drain long results
    typedef enum logic {
        e_normal = 1'b0,
        e_drain  = 1'b1
    } bp_be_wb_arb_state_e;

endpackage

// File: rtl/bp_be_int_wb_arbiter_if.sv
// Bundle of the pipe-result inputs and write-port outputs around the arbiter.
interface bp_be_int_wb_arbiter_if #(
    parameter int unsigned dpath_width_p    = 64,
    parameter int unsigned reg_addr_width_p = 5
);
    logic                        int_v_i;
    logic [dpath_width_p-1:0]    int_data_i;
    logic [reg_addr_width_p-1:0] int_rd_addr_i;
    logic                        long_v_i;
    logic [dpath_width_p-1:0]    long_data_i;
    logic [reg_addr_width_p-1:0] long_rd_addr_i;
    logic                        long_ready_o;
    logic                        int_stall_o;
    logic                        wb_v_o;
    logic [dpath_width_p-1:0]    wb_data_o;
    logic [reg_addr_width_p-1:0] wb_rd_addr_o;
    logic                        wb_src_o;

    // Pipes / register file side
    modport master (
        output int_v_i, int_data_i, int_rd_addr_i,
        output long_v_i, long_data_i, long_rd_addr_i,
        input  long_ready_o, int_stall_o,
        input  wb_v_o, wb_data_o, wb_rd_addr_o, wb_src_o
    );

    // Arbiter side
    modport slave (
        input  int_v_i, int_data_i, int_rd_addr_i,
        input  long_v_i, long_data_i, long_rd_addr_i,
        output long_ready_o, int_stall_o,
        output wb_v_o, wb_data_o, wb_rd_addr_o, wb_src_o
    );
endinterface

// File: rtl/bp_be_int_wb_arbiter_fifo.sv
// Small in-order 1-read/1-write buffer holding waiting long-pipe results.
module bsg_fifo_1r1w_small #(
    parameter int unsigned width_p = 8,
    parameter int unsigned els_p   = 2
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             v_i,
    input  logic [width_p-1:0]               data_i,
    output logic                             ready_o,
    output logic                             v_o,
    output logic [width_p-1:0]               data_o,
    input  logic                             yumi_i,
    output logic [$clog2(els_p+1)-1:0]       count_o
);
    localparam int unsigned ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int unsigned cnt_width_lp = $clog2(els_p + 1);

    logic [width_p-1:0]      mem_r [els_p];
    logic [ptr_width_lp-1:0] rptr_r, wptr_r;
    logic [cnt_width_lp-1:0] count_r;
    logic                    enq, deq;

    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
        return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready depends on occupancy only, never on a same-cycle dequeue
    always_comb begin
        ready_o = (count_r < cnt_width_lp'(els_p));
        v_o     = (count_r != '0);
        enq     = v_i & ready_o;
        deq     = yumi_i & v_o;
        data_o  = mem_r[rptr_r];
        count_o = count_r;
    end

    // Pointer and occupancy tracking; pointers wrap modulo els_p
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rptr_r  <= '0;
            wptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (enq) wptr_r <= ptr_inc(wptr_r);
            if (deq) rptr_r <= ptr_inc(rptr_r);
            count_r <= count_r + cnt_width_lp'(enq) - cnt_width_lp'(deq);
        end
    end

    // Storage write; contents need no reset since occupancy gates reads
    always_ff @(posedge clk_i) begin
        if (enq) mem_r[wptr_r] <= data_i;
    end
endmodule

// File: rtl/bp_be_int_wb_arbiter.sv
// Integer register-file write-port arbiter: int pipe always wins, long-pipe
// results wait in an in-order buffer, and a starvation counter stalls dispatch.
module bp_be_int_wb_arbiter
    import bp_be_pkg::*;
#(
    parameter int unsigned dpath_width_p    = 64,
    parameter int unsigned reg_addr_width_p = 5,
    parameter int unsigned buffer_els_p     = 2,
    parameter int unsigned starve_limit_p   = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    bp_be_int_wb_arbiter_if.slave  wb_arb_if
);
    localparam int unsigned entry_width_lp  = dpath_width_p + reg_addr_width_p;
    localparam int unsigned cnt_width_lp    = $clog2(buffer_els_p + 1);
    localparam int unsigned starve_width_lp = $clog2(starve_limit_p + 1);

    logic                        buf_ready, head_v;
    logic [entry_width_lp-1:0]   head_entry;
    logic [cnt_width_lp-1:0]     buf_count;
    logic                        accept, deq, enq, bypass, buf_empty_next;
    logic                        sel_v;
    logic [dpath_width_p-1:0]    sel_data;
    logic [reg_addr_width_p-1:0] sel_rd_addr;
    bp_be_wb_src_e               sel_src;
    logic [starve_width_lp-1:0]  starve_cnt_r;
    bp_be_wb_arb_state_e         state_r;

    bsg_fifo_1r1w_small #(
        .width_p (entry_width_lp),
        .els_p   (buffer_els_p)
    ) long_buf (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (enq),
        .data_i  ({wb_arb_if.long_rd_addr_i, wb_arb_if.long_data_i}),
        .ready_o (buf_ready),
        .v_o     (head_v),
        .data_o  (head_entry),
        .yumi_i  (deq),
        .count_o (buf_count)
    );

    // Priority select: int pipe, then buffer head, then bypass of a fresh long result
    always_comb begin
        wb_arb_if.long_ready_o = buf_ready;
        accept  = wb_arb_if.long_v_i & buf_ready;
        deq     = ~wb_arb_if.int_v_i & head_v;
        bypass  = ~wb_arb_if.int_v_i & ~head_v & accept;
        enq     = accept & ~bypass;
        sel_v       = 1'b0;
        sel_data    = '0;
        sel_rd_addr = '0;
        sel_src     = e_wb_src_int;
        if (wb_arb_if.int_v_i) begin
            sel_v       = 1'b1;
            sel_data    = wb_arb_if.int_data_i;
            sel_rd_addr = wb_arb_if.int_rd_addr_i;
        end else if (head_v) begin
            sel_v       = 1'b1;
            sel_data    = head_entry[dpath_width_p-1:0];
            sel_rd_addr = head_entry[entry_width_lp-1:dpath_width_p];
            sel_src     = e_wb_src_long;
        end else if (accept) begin
            sel_v       = 1'b1;
            sel_data    = wb_arb_if.long_data_i;
            sel_rd_addr = wb_arb_if.long_rd_addr_i;
            sel_src     = e_wb_src_long;
        end
        // Buffer occupancy after this edge, used to leave drain in the same cycle it empties
        buf_empty_next = ~enq & ((buf_count == '0)
                                 | ((buf_count == cnt_width_lp'(1)) & deq));
    end

    // Starvation counter: counts cycles the head waits, saturating at the limit
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            starve_cnt_r <= '0;
        end else if (~head_v | deq) begin
            starve_cnt_r <= '0;
        end else if (starve_cnt_r != starve_width_lp'(starve_limit_p)) begin
            starve_cnt_r <= starve_cnt_r + 1'b1;
        end
    end

    // Drain FSM with registered dispatch stall
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r               <= e_normal;
            wb_arb_if.int_stall_o <= 1'b0;
        end else begin
            case (state_r)
                e_normal: begin
                    if (starve_cnt_r == starve_width_lp'(starve_limit_p)) begin
                        state_r               <= e_drain;
                        wb_arb_if.int_stall_o <= 1'b1;
                    end
                end
                e_drain: begin
                    if (buf_empty_next) begin
                        state_r               <= e_normal;
                        wb_arb_if.int_stall_o <= 1'b0;
                    end
                end
                default: begin
                    state_r               <= e_normal;
                    wb_arb_if.int_stall_o <= 1'b0;
                end
            endcase
        end
    end

    // Write-port registers; x0 destinations consume the slot without enabling the write
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wb_arb_if.wb_v_o       <= 1'b0;
            wb_arb_if.wb_data_o    <= '0;
            wb_arb_if.wb_rd_addr_o <= '0;
            wb_arb_if.wb_src_o     <= 1'b0;
        end else begin
            wb_arb_if.wb_v_o <= sel_v & (sel_rd_addr != '0);
            if (sel_v) begin
                wb_arb_if.wb_data_o    <= sel_data;
                wb_arb_if.wb_rd_addr_o <= sel_rd_addr;
                wb_arb_if.wb_src_o     <= sel_src;
            end
        end
    end
endmodule

// File: tb/tb_bp_be_int_wb_arbiter.sv
// Self-checking bench for bp_be_int_wb_arbiter: directed table, corner sequences,
// and a randomized run against a queue-based reference model.
module tb_bp_be_int_wb_arbiter;
    localparam int ELS = 2;
    localparam int LIM = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    bp_be_int_wb_arbiter_if #(.dpath_width_p(64), .reg_addr_width_p(5)) bus ();

    bp_be_int_wb_arbiter #(
        .dpath_width_p    (64),
        .reg_addr_width_p (5),
        .buffer_els_p     (ELS),
        .starve_limit_p   (LIM)
    ) dut (
        .clk_i     (clk),
        .reset_i   (rst),
        .wb_arb_if (bus)
    );

    typedef struct {
        logic        iv;
        logic [63:0] id;
        logic [4:0]  ird;
        logic        lv;
        logic [63:0] ld;
        logic [4:0]  lrd;
        logic        e_ready;
        logic        e_v;
        logic [63:0] e_d;
        logic [4:0]  e_rd;
        logic        e_src;
        logic        e_stall;
    } vec_t;

    typedef struct {
        logic [63:0] d;
        logic [4:0]  rd;
    } ent_t;

    // Reference model state
    ent_t mq[$];
    int   m_starve;
    bit   m_drain;

    // Captured DUT values
    logic        g_ready, g_v, g_src, g_stall;
    logic [63:0] g_d;
    logic [4:0]  g_rd;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, got, exp);
        end
    endtask

    // Drive one cycle's inputs, sample ready before the edge and registered outputs after it
    task automatic run_cycle(input logic iv, input logic [63:0] id, input logic [4:0] ird,
                             input logic lv, input logic [63:0] ld, input logic [4:0] lrd,
                             input logic r);
        bus.int_v_i        = iv;
        bus.int_data_i     = id;
        bus.int_rd_addr_i  = ird;
        bus.long_v_i       = lv;
        bus.long_data_i    = ld;
        bus.long_rd_addr_i = lrd;
        rst                = r;
        #4;
        g_ready = bus.long_ready_o;
        @(posedge clk);
        #1;
        g_v     = bus.wb_v_o;
        g_d     = bus.wb_data_o;
        g_rd    = bus.wb_rd_addr_o;
        g_src   = bus.wb_src_o;
        g_stall = bus.int_stall_o;
    endtask

    task automatic m_reset();
        mq.delete();
        m_starve = 0;
        m_drain  = 1'b0;
    endtask

    // Reference: one cycle of arbitration computed from the port rules
    task automatic m_step(input logic iv, input logic [63:0] id, input logic [4:0] ird,
                          input logic lv, input logic [63:0] ld, input logic [4:0] lrd,
                          output logic e_ready, output logic e_v, output logic [63:0] e_d,
                          output logic [4:0] e_rd, output logic e_src, output logic e_stall);
        bit   had, took_head, bypassed, sel, acc;
        int   prev;
        ent_t e;
        e_ready   = (mq.size() < ELS);
        acc       = lv && e_ready;
        had       = (mq.size() > 0);
        took_head = 0;
        bypassed  = 0;
        sel       = 0;
        e_d = '0; e_rd = '0; e_src = 0;
        if (iv) begin
            sel = 1; e_d = id; e_rd = ird; e_src = 0;
        end else if (had) begin
            e = mq.pop_front();
            took_head = 1; sel = 1; e_d = e.d; e_rd = e.rd; e_src = 1;
        end else if (acc) begin
            bypassed = 1; sel = 1; e_d = ld; e_rd = lrd; e_src = 1;
        end
        if (acc && !bypassed) begin
            e.d = ld; e.rd = lrd;
            mq.push_back(e);
        end
        prev = m_starve;
        if (!had || took_head) m_starve = 0;
        else m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
        if (!m_drain) m_drain = (prev == LIM);
        else          m_drain = (mq.size() != 0);
        e_v     = sel && (e_rd != 0);
        e_stall = m_drain;
    endtask

    // Fill the buffer with 0xB/0xC under continuous int traffic until dispatch stalls
    task automatic fill_to_drain(input bit check);
        for (int k = 0; k < 12; k++) begin
            run_cycle(1'b1, 64'(100 + k), 5'((k % 30) + 1),
                      (k < 2), (k == 0) ? 64'hB : 64'hC, (k == 0) ? 5'd4 : 5'd5, 1'b0);
            if (check) begin
                chk($sformatf("starve_ready_%0d", k), 64'(g_ready), (k < 2) ? 64'd1 : 64'd0);
                chk($sformatf("starve_int_wb_%0d", k), g_d, 64'(100 + k));
                chk($sformatf("starve_stall_%0d", k), 64'(g_stall), (k >= 9) ? 64'd1 : 64'd0);
            end
        end
    endtask

    vec_t tbl[10];
    logic        e_ready, e_v, e_src, e_stall;
    logic [63:0] e_d;
    logic [4:0]  e_rd;

    initial begin
        tbl[0] = '{1'b1, 64'h5,  5'd3, 1'b0, 64'h0,  5'd0, 1'b1, 1'b1, 64'h5,  5'd3, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 64'h0,  5'd0, 1'b0, 64'h0,  5'd0, 1'b1, 1'b0, 64'h0,  5'd0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 64'h0,  5'd0, 1'b1, 64'hA,  5'd7, 1'b1, 1'b1, 64'hA,  5'd7, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 64'h11, 5'd1, 1'b1, 64'h22, 5'd2, 1'b1, 1'b1, 64'h11, 5'd1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 64'h0,  5'd0, 1'b0, 64'h0,  5'd0, 1'b1, 1'b1, 64'h22, 5'd2, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 64'h0,  5'd0, 1'b1, 64'h33, 5'd0, 1'b1, 1'b0, 64'h0,  5'd0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 64'h0,  5'd0, 1'b0, 64'h0,  5'd0, 1'b1, 1'b0, 64'h0,  5'd0, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 64'h44, 5'd0, 1'b1, 64'h55, 5'd9, 1'b1, 1'b0, 64'h0,  5'd0, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 64'h0,  5'd0, 1'b0, 64'h0,  5'd0, 1'b1, 1'b1, 64'h55, 5'd9, 1'b1, 1'b0};
        tbl[9] = '{1'b0, 64'h0,  5'd0, 1'b0, 64'h0,  5'd0, 1'b1, 1'b0, 64'h0,  5'd0, 1'b0, 1'b0};

        @(posedge clk);
        #1;
        // Reset state
        run_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        chk("reset_wb_v", 64'(g_v), 64'd0);
        chk("reset_wb_data", g_d, 64'd0);
        chk("reset_wb_rd", 64'(g_rd), 64'd0);
        chk("reset_wb_src", 64'(g_src), 64'd0);
        chk("reset_stall", 64'(g_stall), 64'd0);
        chk("reset_ready", 64'(bus.long_ready_o), 64'd1);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_cycle(tbl[i].iv, tbl[i].id, tbl[i].ird, tbl[i].lv, tbl[i].ld, tbl[i].lrd, 1'b0);
            chk($sformatf("tbl%0d_ready", i), 64'(g_ready), 64'(tbl[i].e_ready));
            chk($sformatf("tbl%0d_wb_v", i), 64'(g_v), 64'(tbl[i].e_v));
            chk($sformatf("tbl%0d_stall", i), 64'(g_stall), 64'(tbl[i].e_stall));
            if (tbl[i].e_v) begin
                chk($sformatf("tbl%0d_data", i), g_d, tbl[i].e_d);
                chk($sformatf("tbl%0d_rd", i), 64'(g_rd), 64'(tbl[i].e_rd));
                chk($sformatf("tbl%0d_src", i), 64'(g_src), 64'(tbl[i].e_src));
            end
        end

        // Starvation: full buffer, continuous int traffic, then drain in order
        run_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        fill_to_drain(1'b1);
        run_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        chk("drain0_ready", 64'(g_ready), 64'd0);
        chk("drain0_wb_v", 64'(g_v), 64'd1);
        chk("drain0_data", g_d, 64'hB);
        chk("drain0_rd", 64'(g_rd), 64'd4);
        chk("drain0_src", 64'(g_src), 64'd1);
        chk("drain0_stall", 64'(g_stall), 64'd1);
        run_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        chk("drain1_ready", 64'(g_ready), 64'd1);
        chk("drain1_data", g_d, 64'hC);
        chk("drain1_rd", 64'(g_rd), 64'd5);
        chk("drain1_stall", 64'(g_stall), 64'd0);
        run_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        chk("drain2_wb_v", 64'(g_v), 64'd0);

        // Reset while draining with a full buffer discards everything
        fill_to_drain(1'b0);
        chk("pre_reset_stall", 64'(g_stall), 64'd1);
        run_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        chk("midrst_wb_v", 64'(g_v), 64'd0);
        chk("midrst_data", g_d, 64'd0);
        chk("midrst_rd", 64'(g_rd), 64'd0);
        chk("midrst_src", 64'(g_src), 64'd0);
        chk("midrst_stall", 64'(g_stall), 64'd0);
        chk("midrst_ready", 64'(bus.long_ready_o), 64'd1);
        for (int k = 0; k < 4; k++) begin
            run_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
            chk($sformatf("postrst_wb_v_%0d", k), 64'(g_v), 64'd0);
        end

        // Randomized traffic against the reference model
        m_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            logic        iv, lv, r;
            logic [63:0] id, ld;
            logic [4:0]  ird, lrd;
            int          ph;
            ph  = (cyc / 400) % 3;
            if (ph == 0)      iv = ($urandom_range(99) < 85);
            else if (ph == 1) iv = ($urandom_range(99) < 30);
            else              iv = (((cyc / 25) % 3) != 0);
            lv  = ($urandom_range(99) < 50);
            id  = {$urandom, $urandom};
            ld  = {$urandom, $urandom};
            ird = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
            lrd = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
            r   = ($urandom_range(699) == 0);
            run_cycle(iv, id, ird, lv, ld, lrd, r);
            if (r) begin
                e_ready = (mq.size() < ELS);
                m_reset();
                e_v = 0; e_d = '0; e_rd = '0; e_src = 0; e_stall = 0;
                chk("rnd_rst_data", g_d, 64'd0);
            end else begin
                m_step(iv, id, ird, lv, ld, lrd, e_ready, e_v, e_d, e_rd, e_src, e_stall);
            end
            chk("rnd_ready", 64'(g_ready), 64'(e_ready));
            chk("rnd_wb_v", 64'(g_v), 64'(e_v));
            chk("rnd_stall", 64'(g_stall), 64'(e_stall));
            if (e_v) begin
                chk("rnd_data", g_d, e_d);
                chk("rnd_rd", 64'(g_rd), 64'(e_rd));
                chk("rnd_src", 64'(g_src), 64'(e_src));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bp_be_int_wb_arbiter.md
# bp_be_int_wb_arbiter

Arbitrates the single integer register-file write port between the single-cycle integer pipe and the long-latency integer pipe (mul/div). It sits between the calculator pipes and the integer register file. The integer pipe has no stall path, so it always wins the port. Long-pipe results are held in a small in-order buffer with a ready/valid handshake. A starvation counter stalls dispatch so that buffered long results eventually drain.

## Interface

Parameters:
- dpath_width_p, 64, result data width
- reg_addr_width_p, 5, architectural register address width
- buffer_els_p, 2, long-result buffer depth (≥1)
- starve_limit_p, 8, cycles a buffered long result may wait before dispatch is stalled (≥1)

Ports:
- clk_i  input  1  clock; single clock domain
- reset_i  input  1  synchronous, active-high reset
- int_v_i  input  1  integer pipe result valid; no backpressure
- int_data_i  input  dpath_width_p  integer pipe result
- int_rd_addr_i  input  reg_addr_width_p  integer pipe destination
- long_v_i  input  1  long pipe result valid
- long_data_i  input  dpath_width_p  long pipe result
- long_rd_addr_i  input  reg_addr_width_p  long pipe destination
- long_ready_o  output  1  arbiter can accept a long result this cycle
- int_stall_o  output  1  registered; dispatch must stop issuing integer-pipe ops
- wb_v_o  output  1  registered write-port enable
- wb_data_o  output  dpath_width_p  registered write data
- wb_rd_addr_o  output  reg_addr_width_p  registered write address
- wb_src_o  output  1  registered source tag; 0 = int, 1 = long

## Operation

- Long handshake: a result transfers when long_v_i & long_ready_o.
  - long_ready_o = (buffer count < buffer_els_p).
  - It depends on count only, not on a same-cycle dequeue. A full buffer with a dequeue this cycle still reports 0.
- Selection priority, evaluated each cycle:
  1. int_v_i
  2. buffer head
  3. accepted long result, as a bypass; allowed only when the buffer is empty
- Enqueue: an accepted long result that is not selected enters the buffer.
- Ordering: long results retire in acceptance order. Bypass is never taken while the buffer is non-empty.
- x0 handling: a selected result with rd_addr == 0 produces wb_v_o = 0 but still consumes its slot or buffer entry.
- Starvation counter:
  - Increments each cycle the buffer is non-empty and its head is not selected.
  - Clears when the head is dequeued or the buffer is empty.
  - Saturates at starve_limit_p.
- FSM:
  - e_normal → e_drain when the counter reaches starve_limit_p.
  - e_drain → e_normal in the cycle the buffer becomes empty.
  - int_stall_o is 1 whenever the registered state is e_drain.
- int_v_i arriving during e_drain (ops already in flight) still wins the port. The buffer drains once int_v_i drops.
- flush_i is deliberately absent. Results reaching this block are committed and always written.

## Timing

- Reset values: wb_v_o = 0, wb_data_o = 0, wb_rd_addr_o = 0, wb_src_o = 0, int_stall_o = 0. Buffer empty, counter 0, state e_normal. long_ready_o is therefore 1 in the first cycle after reset.
- Reset mid-operation discards all buffered results.
- Latency: the selected input appears on wb_* at the next clock edge (1 cycle). Bypass latency is 1 cycle. Buffered latency is 1 cycle plus the wait time.
- Buffer full and int_v_i every cycle: long_ready_o stays 0.
  - int_stall_o asserts starve_limit_p+1 cycles after the head first waits. The counter saturates at starve_limit_p, and the state register updates one edge later.
- Simultaneous int_v_i and long_v_i with the buffer empty and ready: int is written, and the long result is enqueued.
- Simultaneous dequeue and enqueue on a full buffer cannot occur, because ready is 0.
- Count wrap: the buffer pointers wrap modulo buffer_els_p.

## Structure

- bp_be_pkg: enum bp_be_wb_src_e {e_wb_src_int, e_wb_src_long}; enum bp_be_wb_arb_state_e {e_normal, e_drain}.
- Sub-module: bsg_fifo_1r1w_small, width dpath_width_p + reg_addr_width_p, depth buffer_els_p, for the long-result buffer.
- Arbiter top: selection, counter, FSM, output registers.

## Test plan

- Reset, then int_v_i = 1, data 0x5, rd 3 → next cycle wb_v_o = 1, wb_data_o = 0x5, wb_rd_addr_o = 3, wb_src_o = 0.
- Idle, then long_v_i = 1, data 0xA, rd 7 → bypass; next cycle wb_src_o = 1, data 0xA; buffer stays empty.
- Same cycle int (rd 1) and long (rd 2) → int written at T+1; long written at T+2 with src 1.
- Long results 0xB then 0xC while int_v_i = 1 every cycle; buffer_els_p = 2 → long_ready_o = 0 with 2 entries buffered. After the counter saturates, int_stall_o = 1; drop int_v_i → 0xB, then 0xC written in order; int_stall_o returns to 0.
- Long result with rd 0 accepted → wb_v_o stays 0; no buffer entry remains.
- Assert reset_i with the buffer holding 2 entries and state e_drain → all outputs 0, long_ready_o = 1; no buffered result is ever written.
